// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between IM fetches and DM loads/stores. Grants come 1 cycle after the request and read data MEM_LAT+2 cycles after it.
// One access is outstanding at a time. A request is not accepted while busy, and the requester holds req until it sees gnt.
module mem_port_arbiter #(
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 32,
  parameter int MEM_LAT       = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              im_req_i,
  input  logic [ADDR_W-3:0] im_addr_i,
  output logic              im_gnt_o,
  output logic              im_rvalid_o,
  output logic [DATA_W-1:0] im_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

  state_t              state_q, state_d;
  logic [3:0]          streak_q, streak_d;
  logic [2:0]          wait_q, wait_d;
  logic                owner_dm_q, owner_dm_d;
  logic                im_gnt_q, im_gnt_d, dm_gnt_q, dm_gnt_d;
  logic                im_rvalid_q, im_rvalid_d, dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0]   im_rdata_q, im_rdata_d, dm_rdata_q, dm_rdata_d;
  logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                grant_im;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    wait_d      = wait_q;
    owner_dm_d  = owner_dm_q;
    im_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    im_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    im_rdata_d  = im_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    grant_im    = im_req_i && (!dm_req_i || streak_q == STREAK_MAX);
    case (state_q)
      IDLE: begin
        if (im_req_i || dm_req_i) begin
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          if (grant_im) begin
            im_gnt_d   = 1'b1;
            owner_dm_d = 1'b0;
            mem_addr_d = {im_addr_i, 2'b00};
            streak_d   = '0;
          end else begin
            dm_gnt_d    = 1'b1;
            owner_dm_d  = 1'b1;
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
            // A DM win only counts against a fetch that is actually waiting.
            if (!im_req_i)                 streak_d = '0;
            else if (streak_q != STREAK_MAX) streak_d = streak_q + 4'd1;
          end
        end
      end
      ISSUE: begin
        if (mem_we_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          wait_d  = 3'(MEM_LAT);
        end
      end
      WAIT: begin
        wait_d = wait_q - 3'd1;
        if (wait_q == 3'd1) begin
          state_d = IDLE;
          if (owner_dm_q) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = mem_rdata_i;
          end else begin
            im_rvalid_d = 1'b1;
            im_rdata_d  = mem_rdata_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      wait_q      <= '0;
      owner_dm_q  <= 1'b0;
      im_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      im_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      im_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      wait_q      <= wait_d;
      owner_dm_q  <= owner_dm_d;
      im_gnt_q    <= im_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      im_rvalid_q <= im_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      im_rdata_q  <= im_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign im_gnt_o    = im_gnt_q;
  assign dm_gnt_o    = dm_gnt_q;
  assign im_rvalid_o = im_rvalid_q;
  assign dm_rvalid_o = dm_rvalid_q;
  assign im_rdata_o  = im_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. A latency-accurate SRAM model and a schedule-level reference model are checked every cycle.
// Directed cases pin the literal values. A second instance covers a 3-cycle memory latency.
module tb_mem_port_arbiter;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int LAT  = 1;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst;
  logic im_req, dm_req, dm_we;
  logic [AW-3:0] im_addr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic im_gnt, im_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we;
  logic [DW-1:0] im_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  logic          d3_dm_req;
  logic [AW-1:0] d3_dm_addr;
  logic [DW-1:0] d3_mem_rdata;
  logic d3_im_gnt, d3_im_rvalid, d3_dm_gnt, d3_dm_rvalid, d3_mem_en, d3_mem_we;
  logic [DW-1:0] d3_im_rdata, d3_dm_rdata, d3_mem_wdata;
  logic [AW-1:0] d3_mem_addr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_DM_STREAK(MAXS)) u_dut (
    .clk(clk), .rst(rst),
    .im_req_i(im_req), .im_addr_i(im_addr), .im_gnt_o(im_gnt),
    .im_rvalid_o(im_rvalid), .im_rdata_o(im_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .MAX_DM_STREAK(MAXS)) u_dut3 (
    .clk(clk), .rst(rst),
    .im_req_i(1'b0), .im_addr_i('0), .im_gnt_o(d3_im_gnt),
    .im_rvalid_o(d3_im_rvalid), .im_rdata_o(d3_im_rdata),
    .dm_req_i(d3_dm_req), .dm_we_i(1'b0), .dm_addr_i(d3_dm_addr), .dm_wdata_i('0),
    .dm_gnt_o(d3_dm_gnt), .dm_rvalid_o(d3_dm_rvalid), .dm_rdata_o(d3_dm_rdata),
    .mem_en_o(d3_mem_en), .mem_we_o(d3_mem_we), .mem_addr_o(d3_mem_addr),
    .mem_wdata_o(d3_mem_wdata), .mem_rdata_i(d3_mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // SRAM contents, shared by the bus model and the reference model.
  logic [DW-1:0] mem [0:1023];
  int            rd_due = -1;
  logic [DW-1:0] rd_dat;

  // Expected outputs for the current cycle, and the reference model's schedule.
  logic          e_im_gnt = 0, e_dm_gnt = 0, e_im_rv = 0, e_dm_rv = 0, e_en = 0, e_we = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_im_rd = '0, e_dm_rd = '0;
  int            free_cyc = 0, streak = 0, rv_cyc = -1;
  logic          rv_dm = 0;
  logic [DW-1:0] rv_dat = '0;

  always @(negedge clk) begin
    automatic int  c = cyc;
    automatic logic win_im, is_rd;
    automatic logic [DW-1:0] dat;
    chk("im_gnt", 32'(im_gnt), 32'(e_im_gnt));
    chk("dm_gnt", 32'(dm_gnt), 32'(e_dm_gnt));
    chk("im_rvalid", 32'(im_rvalid), 32'(e_im_rv));
    chk("dm_rvalid", 32'(dm_rvalid), 32'(e_dm_rv));
    chk("im_rdata", im_rdata, e_im_rd);
    chk("dm_rdata", dm_rdata, e_dm_rd);
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", mem_wdata, e_wdata);

    // SRAM: data for a read issued in cycle k is presented only in cycle k+LAT.
    if (mem_en === 1'b1 && mem_we === 1'b1) mem[mem_addr[AW-1:2]] = mem_wdata;
    if (mem_en === 1'b1 && mem_we === 1'b0) begin
      rd_due = c + LAT;
      rd_dat = mem[mem_addr[AW-1:2]];
    end
    mem_rdata = (c == rd_due) ? rd_dat : $urandom;

    // Reference: outputs for cycle c+1 from the request seen in cycle c.
    e_im_gnt = 0; e_dm_gnt = 0; e_im_rv = 0; e_dm_rv = 0;
    e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    if (rst) begin
      e_im_rd = '0; e_dm_rd = '0; streak = 0; free_cyc = c + 1; rv_cyc = -1;
    end else begin
      if (rv_cyc == c + 1) begin
        if (rv_dm) begin e_dm_rv = 1; e_dm_rd = rv_dat; end
        else       begin e_im_rv = 1; e_im_rd = rv_dat; end
      end
      if (c == free_cyc) begin
        if (im_req || dm_req) begin
          win_im = im_req && (!dm_req || streak == MAXS);
          e_en = 1;
          if (win_im) begin
            e_im_gnt = 1; e_addr = {im_addr, 2'b00};
            streak = 0; is_rd = 1; rv_dm = 0; dat = mem[im_addr];
          end else begin
            e_dm_gnt = 1; e_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata;
            streak = im_req ? ((streak + 1 > MAXS) ? MAXS : streak + 1) : 0;
            is_rd = !dm_we; rv_dm = 1; dat = mem[dm_addr[AW-1:2]];
          end
          if (is_rd) begin
            rv_cyc = c + 2 + LAT; rv_dat = dat; free_cyc = c + 2 + LAT;
          end else begin
            free_cyc = c + 2;
          end
        end else begin
          free_cyc = c + 1;
        end
      end
    end
  end

  initial begin
    automatic int glist[$];
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[4] = 32'hDEADBEEF;
    rst = 1; im_req = 0; im_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    d3_dm_req = 0; d3_dm_addr = '0; d3_mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_im_rdata", im_rdata, 32'd0);
    chk("rst_d3_dm_gnt", 32'(d3_dm_gnt), 32'd0);

    // 3-cycle latency load on the second instance.
    next_cyc(); d3_dm_req = 1; d3_dm_addr = 12'h020;
    next_cyc(); d3_dm_req = 0;
    @(negedge clk);
    chk("lat3_gnt", 32'(d3_dm_gnt), 32'd1);
    chk("lat3_en", 32'(d3_mem_en), 32'd1);
    chk("lat3_addr", 32'(d3_mem_addr), 32'h020);
    chk("lat3_we", 32'(d3_mem_we), 32'd0);
    next_cyc(); d3_mem_rdata = $urandom;
    @(negedge clk); chk("lat3_en_c2", 32'(d3_mem_en), 32'd0);
    next_cyc(); d3_mem_rdata = $urandom;
    next_cyc(); d3_mem_rdata = 32'hCAFEF00D;
    @(negedge clk); chk("lat3_rv_c4", 32'(d3_dm_rvalid), 32'd0);
    next_cyc(); d3_mem_rdata = $urandom;
    @(negedge clk);
    chk("lat3_rv_c5", 32'(d3_dm_rvalid), 32'd1);
    chk("lat3_rdata", d3_dm_rdata, 32'hCAFEF00D);
    chk("lat3_im_rv", 32'(d3_im_rvalid), 32'd0);
    next_cyc();
    @(negedge clk); chk("lat3_rv_c6", 32'(d3_dm_rvalid), 32'd0);

    // Single fetch.
    next_cyc(); im_req = 1; im_addr = 10'h004;
    next_cyc(); im_req = 0;
    @(negedge clk);
    chk("fetch_gnt", 32'(im_gnt), 32'd1);
    chk("fetch_en", 32'(mem_en), 32'd1);
    chk("fetch_addr", 32'(mem_addr), 32'h010);
    chk("fetch_we", 32'(mem_we), 32'd0);
    next_cyc();
    @(negedge clk); chk("fetch_rv_c2", 32'(im_rvalid), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("fetch_rv_c3", 32'(im_rvalid), 32'd1);
    chk("fetch_rdata", im_rdata, 32'hDEADBEEF);
    chk("fetch_dm_rv", 32'(dm_rvalid), 32'd0);

    // Store, then an immediate fetch of the same word to confirm the return to IDLE in cycle 2.
    next_cyc(); dm_req = 1; dm_we = 1; dm_addr = 12'h3FC; dm_wdata = 32'h12345678;
    next_cyc(); dm_req = 0; dm_we = 0;
    @(negedge clk);
    chk("store_gnt", 32'(dm_gnt), 32'd1);
    chk("store_en", 32'(mem_en), 32'd1);
    chk("store_we", 32'(mem_we), 32'd1);
    chk("store_addr", 32'(mem_addr), 32'h3FC);
    chk("store_wdata", mem_wdata, 32'h12345678);
    next_cyc(); im_req = 1; im_addr = 10'h0FF;
    next_cyc(); im_req = 0;
    @(negedge clk);
    chk("store_idle_gnt", 32'(im_gnt), 32'd1);
    chk("store_idle_addr", 32'(mem_addr), 32'h3FC);
    next_cyc();
    @(negedge clk); chk("store_dm_rv", 32'(dm_rvalid), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("readback_rv", 32'(im_rvalid), 32'd1);
    chk("readback_rdata", im_rdata, 32'h12345678);
    chk("store_dm_rv2", 32'(dm_rvalid), 32'd0);

    // Collision followed by sustained DM loads with a fetch waiting.
    next_cyc(); im_req = 1; im_addr = 10'h004; dm_req = 1; dm_we = 0; dm_addr = 12'h040;
    next_cyc();
    @(negedge clk);
    chk("coll_dm_gnt", 32'(dm_gnt), 32'd1);
    chk("coll_im_gnt", 32'(im_gnt), 32'd0);
    glist.push_back(0);
    for (int i = 0; i < 60 && glist.size() < 6; i++) begin
      next_cyc();
      if (im_gnt) begin glist.push_back(1); im_req = 0; end
      if (dm_gnt) glist.push_back(0);
    end
    dm_req = 0; im_req = 0;
    chk("starve_grants", 32'(glist.size()), 32'd6);
    while (glist.size() < 6) glist.push_back(2);
    for (int i = 0; i < 6; i++) chk($sformatf("starve_g%0d", i), 32'(glist[i]), (i == 4) ? 32'd1 : 32'd0);

    // Reset during the WAIT of a fetch.
    repeat (8) next_cyc();
    im_req = 1; im_addr = 10'h004;
    next_cyc(); im_req = 0;
    next_cyc(); rst = 1;
    next_cyc(); rst = 0;
    @(negedge clk);
    chk("rstw_im_rv", 32'(im_rvalid), 32'd0);
    chk("rstw_im_rdata", im_rdata, 32'd0);
    chk("rstw_mem_en", 32'(mem_en), 32'd0);
    chk("rstw_im_gnt", 32'(im_gnt), 32'd0);
    next_cyc(); im_req = 1; im_addr = 10'h004;
    @(negedge clk); chk("rstw_im_rv2", 32'(im_rvalid), 32'd0);
    next_cyc(); im_req = 0;
    @(negedge clk); chk("rstw_regrant", 32'(im_gnt), 32'd1);
    next_cyc(); next_cyc();
    @(negedge clk);
    chk("rstw_rv", 32'(im_rvalid), 32'd1);
    chk("rstw_rdata", im_rdata, 32'hDEADBEEF);

    // Random traffic with occasional drops and resets.
    for (int i = 0; i < 3000; i++) begin
      next_cyc();
      rst = ($urandom_range(499) == 0);
      if (im_gnt) im_req = 0;
      if (dm_gnt) dm_req = 0;
      if (!im_req && $urandom_range(2) == 0) begin
        im_req = 1; im_addr = (AW-2)'($urandom);
      end else if (im_req && $urandom_range(31) == 0) im_req = 0;
      if (!dm_req && $urandom_range(1) == 0) begin
        dm_req = 1; dm_we = $urandom_range(1) == 1; dm_addr = AW'($urandom); dm_wdata = $urandom;
      end else if (dm_req && $urandom_range(31) == 0) dm_req = 0;
    end
    rst = 0; im_req = 0; dm_req = 0;
    repeat (10) next_cyc();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified SRAM between the instruction-fetch requester (IM side, word-addressed) and the load/store requester (DM side, byte-addressed). Each access is a req/gnt handshake with one access outstanding at a time. Data requests take priority. A streak limiter ensures a waiting fetch is served within a bounded number of data grants. It sits between the CPU core's IM/DM ports and the memory macro.

Parameters:
ADDR_W, 12, memory byte-address width; IM word address is ADDR_W-2 bits.
DATA_W, 32, data width.
MEM_LAT, 1, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..4.
MAX_DM_STREAK, 4, number of consecutive DM grants allowed while im_req is pending, after which the next grant goes to IM; legal range 1..15.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
im_req  in  1  fetch request; held until im_gnt is seen
im_addr  in  ADDR_W-2  fetch word address
im_gnt  out  1  one-cycle grant pulse (fetch issued)
im_rvalid  out  1  one-cycle pulse; im_rdata valid
im_rdata  out  DATA_W  fetched instruction
dm_req  in  1  data request; held until dm_gnt is seen
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data byte address
dm_wdata  in  DATA_W  store data
dm_gnt  out  1  one-cycle grant pulse
dm_rvalid  out  1  one-cycle pulse for loads only
dm_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data

Behaviour:
- All outputs are registered. On reset every output is 0, state = IDLE, streak counter = 0, wait counter = 0, and the owner flag is cleared.
- FSM: IDLE -> ISSUE -> (read: WAIT -> IDLE | write: IDLE).
- IDLE: arbitrates on the current-cycle im_req/dm_req. If neither is asserted, stay in IDLE.
- Grant priority: DM first, unless im_req=1 and streak == MAX_DM_STREAK; in that case grant IM.
- Streak counter:
  - +1 on each DM grant made while im_req=1 (saturates at MAX_DM_STREAK).
  - Cleared on any IM grant.
  - Cleared on a DM grant made while im_req=0.
- ISSUE (exactly 1 cycle):
  - The winner's gnt = 1, mem_en = 1.
  - IM winner: mem_addr = {im_addr, 2'b00}, mem_we = 0.
  - DM winner: mem_addr = dm_addr, mem_we = dm_we, mem_wdata = dm_wdata.
  - Owner (IM/DM) is latched.
  - Next state: store -> IDLE; any read -> WAIT with the wait counter loaded to MEM_LAT.
- WAIT: mem_en = 0; the counter decrements each cycle. In the cycle it reads 1, mem_rdata is captured into the owner's rdata register and the FSM goes to IDLE.
- The owner's rvalid pulses for exactly one cycle: the first IDLE cycle after WAIT. Arbitration in that same IDLE cycle is allowed (back-to-back).
- Latency, MEM_LAT=1, request sampled in IDLE cycle 0:
  - gnt/mem_en in cycle 1.
  - mem_rdata valid in cycle 2.
  - rvalid in cycle 3.
  - Next ISSUE no earlier than cycle 4.
  - Store: ISSUE in cycle 1, IDLE in cycle 2, next ISSUE in cycle 3.
- Requests are ignored outside IDLE. A requester that drops req before its gnt simply loses that arbitration; no state is kept for it.
- rdata registers hold their last captured value until the next capture for the same owner. The non-owner's rdata is never modified.
- mem_addr, mem_we and mem_wdata return to 0 whenever mem_en = 0.
- Reset mid-operation (ISSUE or WAIT): the in-flight access is abandoned, no rvalid is produced, and everything returns to reset values on the next edge.
- No combinational path from any input to any output.

Test Plan:
- Single fetch, MEM_LAT=1: im_req=1, im_addr=10'h004 in IDLE cycle 0 -> im_gnt=1, mem_en=1, mem_addr=12'h010, mem_we=0 in cycle 1; mem_rdata=32'hDEADBEEF in cycle 2 -> im_rvalid=1, im_rdata=32'hDEADBEEF in cycle 3; dm_rvalid stays 0.
- Store: dm_req=1, dm_we=1, dm_addr=12'h3FC, dm_wdata=32'h12345678 -> cycle 1 mem_en=1, mem_we=1, mem_addr=12'h3FC, mem_wdata=32'h12345678, dm_gnt=1; FSM in IDLE in cycle 2; no dm_rvalid ever.
- Collision: im_req and dm_req both 1 in cycle 0 with streak=0 -> dm_gnt in cycle 1, im_gnt=0, streak=1.
- Starvation bound, MAX_DM_STREAK=4: continuous DM loads plus im_req held high -> 4 dm_gnt pulses, then the 5th grant is im_gnt, streak=0, then DM resumes.
- MEM_LAT=3 load: dm_req load at 12'h020 -> mem_en in cycle 1; mem_rdata sampled in cycle 4; dm_rvalid in cycle 5 carrying the cycle-4 mem_rdata.
- Reset in WAIT: rst=1 during the WAIT of an IM read -> the next cycle has all outputs 0, im_rvalid is never asserted, and the next im_req is granted normally after rst drops.
